// File: rtl/imem_responder.sv
// Memory-side responder for the processor memory bus: same-cycle accept/reject, fixed-latency completion.
// Optional macro IMEM_RESP_RANDOM_REJECT_EN adds LFSR-driven pseudo-random rejection of requests.
module imem_responder #(
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_WORDS       = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [3:0] MAX_CNT   = 4'(MAX_OUTSTANDING);

  logic [63:0] mem_q [MEM_WORDS];

  // Delay line: a zero tag marks an empty stage, and empty stages carry zero data.
  logic [3:0]  tag_q  [LATENCY];
  logic [63:0] data_q [LATENCY];

  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  next_tag_q, next_tag_d;
  logic [IDX_W-1:0] idx;
  logic        is_load, is_store, cap_ok, rand_ok, accept, complete;
  logic        unused_addr_bits;

  assign idx              = proc2mem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{proc2mem_addr[31:3+IDX_W], proc2mem_addr[2:0]};

  assign is_load  = (proc2mem_command == BUS_LOAD);
  assign is_store = (proc2mem_command == BUS_STORE);
  assign cap_ok   = (cnt_q < MAX_CNT);

`ifdef IMEM_RESP_RANDOM_REJECT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign rand_ok = (lfsr_q[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign rand_ok = 1'b1;
`endif

  assign accept            = (is_load || is_store) && cap_ok && rand_ok;
  assign mem2proc_response = accept ? next_tag_q : 4'd0;
  assign complete          = (tag_q[LATENCY-1] != 4'd0);

  assign mem2proc_tag  = tag_q[LATENCY-1];
  assign mem2proc_data = data_q[LATENCY-1];

  // A completion in the same cycle as an accept leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, complete})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    next_tag_d = next_tag_q;
    if (accept) next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      next_tag_q <= 4'd1;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i]  <= 4'd0;
        data_q[i] <= 64'd0;
      end
    end else begin
      cnt_q      <= cnt_d;
      next_tag_q <= next_tag_d;
      tag_q[0]   <= accept ? next_tag_q : 4'd0;
      data_q[0]  <= (accept && is_load) ? mem_q[idx] : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (!reset && accept && is_store) mem_q[idx] <= proc2mem_data;
  end

endmodule
